fpu_regfile_wb: RTL and testbench
=================================

// Module: fpu_regfile_wb
// PURPOSE
//  Register-file storage and write-back stage for the FP co-processor; drives the output-select mux.
//  Holds NUM_REGS x DATA_W registers and arbitrates three write sources: FPU result, SRAM load, host write.
//  Keeps a per-register busy scoreboard (set at op issue, cleared at FPU write-back) to block WAW hazards.
//  Exports all registers in parallel; the top level slices them onto the mux reg0..reg15 inputs.
// PARAMETERS
//  NUM_REGS  16  number of architectural registers
//  DATA_W    32  register width (IEEE-754 single)
//  ADDR_W    4   register index width, = $clog2(NUM_REGS)
// PORTS
//  clk          in   1                  system clock, rising edge
//  n_rst        in   1                  asynchronous reset, active low
//  fpu_wb_valid in   1                  FPU result valid (no ready; always accepted)
//  fpu_wb_addr  in   ADDR_W             FPU destination register
//  fpu_wb_data  in   DATA_W             FPU result
//  sram_w_valid in   1                  SRAM load write request
//  sram_w_addr  in   ADDR_W             SRAM load destination
//  sram_w_data  in   DATA_W             SRAM load data
//  sram_w_ready out  1                  SRAM load accepted this cycle
//  host_w_valid in   1                  host write request
//  host_w_addr  in   ADDR_W             host write destination
//  host_w_data  in   DATA_W             host write data
//  host_w_ready out  1                  host write accepted this cycle
//  issue_valid  in   1                  FPU op issued; reserves issue_dest
//  issue_dest   in   ADDR_W             destination register of issued op
//  issue_ready  out  1                  issue may proceed (issue_dest not busy)
//  reg_out      out  NUM_REGS*DATA_W    register i at [i*DATA_W +: DATA_W]
//  busy         out  NUM_REGS           scoreboard, bit i = reg i awaiting FPU result
//  wb_err       out  1                  sticky: FPU wrote a non-busy register
// BEHAVIOUR
//  Reset (n_rst low, async): all registers 0, busy 0, wb_err 0; held while n_rst low.
//  Clock and reset fixed: single clock clk; reset n_rst is asynchronous, active low.
//  Write priority, fixed: FPU > SRAM > host. One register write per cycle.
//  sram_w_ready = !fpu_wb_valid && !busy[sram_w_addr].
//  host_w_ready = !fpu_wb_valid && !sram_w_valid && !busy[host_w_addr].
//  Readies are combinational. A request is accepted on the edge where valid && ready.
//  Requesters hold valid/addr/data stable until accepted.
//  Latency: accepted write appears on reg_out the cycle after the accepting edge.
//  No write-through bypass to reg_out.
//  issue_ready = !busy[issue_dest]; on issue_valid && issue_ready, busy[issue_dest] <= 1.
//  On fpu_wb_valid: write data; busy[fpu_wb_addr] <= 0.
//  If busy[fpu_wb_addr] was 0, wb_err <= 1; the data is still written.
//  Same-cycle issue and FPU write-back to the same register: issue_ready is 0 (busy set), so no set.
//  Busy clears; the issuer retries next cycle.
//  Issue and write-back to different registers in the same cycle: both updates take effect.
//  SRAM/host writes never touch busy. Writes to a busy register stall until it clears.
//  wb_err clears only on reset.
//  Reset mid-operation: pending valids are dropped, scoreboard cleared; requesters must re-present.
//  Address range: ADDR_W covers NUM_REGS exactly; every address is legal.
// STRUCTURE
//  Shared package fpu_rf_pkg: NUM_REGS/DATA_W/ADDR_W constants.
//  Package also holds typedef logic [DATA_W-1:0] fp_word_t and typedef logic [ADDR_W-1:0] reg_idx_t.
//  One sub-module: rf_write_arb (3-source priority arbiter -> wr_en, wr_addr, wr_data, per-source ready).
//  Storage, scoreboard and wb_err live in the top module.
// TESTING
//  Reset: drive n_rst low mid-cycle -> reg_out=0, busy=0, wb_err=0 immediately.
//  Reset while issue pending -> busy cleared.
//  Host write r3=0x3F800000 alone -> host_w_ready=1; next cycle reg_out[3]=0x3F800000.
//  Collision: FPU r1=0x40000000, SRAM r2=0x40400000, host r4=0x40800000 same cycle.
//    Cycle 1: only r1 written, sram/host ready=0.
//    Cycle 2: r2 written. Cycle 3: r4 written.
//  Scoreboard: issue r5 -> busy[5]=1.
//    Host write r5 -> host_w_ready=0 held.
//    FPU wb r5=0xC0000000 -> busy[5]=0; host write accepted next cycle and overwrites.
//  Issue r7 while busy[7]=1 -> issue_ready=0; after FPU wb r7, issue_ready=1.
//  Issue r6 and FPU wb r6 in the same cycle -> issue_ready=0, busy[6]=0 after the edge.
//  Spurious FPU wb to r9 (busy=0), data 0x12345678 -> reg_out[9]=0x12345678, wb_err=1.
//    wb_err stays 1 until reset.

Source files
------------

// File: rtl/fpu_rf_pkg.sv
// Shared constants and types for the FP co-processor register file and its
// write-back arbiter.
package fpu_rf_pkg;

  localparam int NUM_REGS = 16;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef logic [DATA_W-1:0] fp_word_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;

  // One granted register-file write per cycle.
  typedef struct packed {
    logic     valid;
    reg_idx_t addr;
    fp_word_t data;
  } wr_req_t;

endpackage

// File: rtl/rf_write_arb.sv
// Fixed-priority write arbiter for the register file: FPU result beats SRAM
// load, which beats host write. Busy registers hold off SRAM/host writes.
module rf_write_arb
  import fpu_rf_pkg::*;
(
  input  logic     fpu_valid,
  input  reg_idx_t fpu_addr,
  input  fp_word_t fpu_data,
  input  logic     sram_valid,
  input  reg_idx_t sram_addr,
  input  fp_word_t sram_data,
  input  logic     sram_busy,
  input  logic     host_valid,
  input  reg_idx_t host_addr,
  input  fp_word_t host_data,
  input  logic     host_busy,
  output logic     sram_ready,
  output logic     host_ready,
  output wr_req_t  wr
);

  // FPU has no ready and is always taken, so it only needs to gate the others.
  always_comb begin
    sram_ready = !fpu_valid && !sram_busy;
    host_ready = !fpu_valid && !sram_valid && !host_busy;
    wr         = '0;
    if (fpu_valid) begin
      wr.valid = 1'b1;
      wr.addr  = fpu_addr;
      wr.data  = fpu_data;
    end else if (sram_valid && sram_ready) begin
      wr.valid = 1'b1;
      wr.addr  = sram_addr;
      wr.data  = sram_data;
    end else if (host_valid && host_ready) begin
      wr.valid = 1'b1;
      wr.addr  = host_addr;
      wr.data  = host_data;
    end
  end

endmodule

// File: rtl/fpu_regfile_wb.sv
// Register file and write-back stage of the FP co-processor: storage, busy
// scoreboard for outstanding FPU results, and a sticky spurious-write flag.
module fpu_regfile_wb
  import fpu_rf_pkg::*;
(
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       fpu_wb_valid,
  input  reg_idx_t                   fpu_wb_addr,
  input  fp_word_t                   fpu_wb_data,
  input  logic                       sram_w_valid,
  input  reg_idx_t                   sram_w_addr,
  input  fp_word_t                   sram_w_data,
  output logic                       sram_w_ready,
  input  logic                       host_w_valid,
  input  reg_idx_t                   host_w_addr,
  input  fp_word_t                   host_w_data,
  output logic                       host_w_ready,
  input  logic                       issue_valid,
  input  reg_idx_t                   issue_dest,
  output logic                       issue_ready,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  output logic [NUM_REGS-1:0]        busy,
  output logic                       wb_err
);

  wr_req_t  wr;
  fp_word_t regs [NUM_REGS];

  rf_write_arb u_arb (
    .fpu_valid  (fpu_wb_valid),
    .fpu_addr   (fpu_wb_addr),
    .fpu_data   (fpu_wb_data),
    .sram_valid (sram_w_valid),
    .sram_addr  (sram_w_addr),
    .sram_data  (sram_w_data),
    .sram_busy  (busy[sram_w_addr]),
    .host_valid (host_w_valid),
    .host_addr  (host_w_addr),
    .host_data  (host_w_data),
    .host_busy  (busy[host_w_addr]),
    .sram_ready (sram_w_ready),
    .host_ready (host_w_ready),
    .wr         (wr)
  );

  assign issue_ready = !busy[issue_dest];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr.valid) begin
      regs[wr.addr] <= wr.data;
    end
  end

  // An accepted issue is applied after the write-back clear, so a reservation
  // the issuer saw granted is never lost to a same-register spurious write-back.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy   <= '0;
      wb_err <= 1'b0;
    end else begin
      if (fpu_wb_valid) begin
        busy[fpu_wb_addr] <= 1'b0;
        if (!busy[fpu_wb_addr]) wb_err <= 1'b1;
      end
      if (issue_valid && issue_ready) busy[issue_dest] <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
    assign reg_out[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_fpu_regfile_wb.sv
// Self-checking bench for fpu_regfile_wb: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_fpu_regfile_wb;
  import fpu_rf_pkg::*;

  logic                       clk = 1'b0;
  logic                       n_rst;
  logic                       fpu_wb_valid;
  reg_idx_t                   fpu_wb_addr;
  fp_word_t                   fpu_wb_data;
  logic                       sram_w_valid;
  reg_idx_t                   sram_w_addr;
  fp_word_t                   sram_w_data;
  logic                       sram_w_ready;
  logic                       host_w_valid;
  reg_idx_t                   host_w_addr;
  fp_word_t                   host_w_data;
  logic                       host_w_ready;
  logic                       issue_valid;
  reg_idx_t                   issue_dest;
  logic                       issue_ready;
  logic [NUM_REGS*DATA_W-1:0] reg_out;
  logic [NUM_REGS-1:0]        busy;
  logic                       wb_err;

  int checks   = 0;
  int failures = 0;

  fp_word_t            m_reg [NUM_REGS];
  logic [NUM_REGS-1:0] m_busy;
  logic                m_err;
  logic                sram_acc;
  logic                host_acc;

  always #5 clk = ~clk;

  fpu_regfile_wb dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .fpu_wb_valid (fpu_wb_valid),
    .fpu_wb_addr  (fpu_wb_addr),
    .fpu_wb_data  (fpu_wb_data),
    .sram_w_valid (sram_w_valid),
    .sram_w_addr  (sram_w_addr),
    .sram_w_data  (sram_w_data),
    .sram_w_ready (sram_w_ready),
    .host_w_valid (host_w_valid),
    .host_w_addr  (host_w_addr),
    .host_w_data  (host_w_data),
    .host_w_ready (host_w_ready),
    .issue_valid  (issue_valid),
    .issue_dest   (issue_dest),
    .issue_ready  (issue_ready),
    .reg_out      (reg_out),
    .busy         (busy),
    .wb_err       (wb_err)
  );

  task automatic expectVal(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic fp_word_t regOf(input int i);
    return reg_out[i*DATA_W +: DATA_W];
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < NUM_REGS; i++) m_reg[i] = '0;
    m_busy = '0;
    m_err  = 1'b0;
  endfunction

  function automatic logic [NUM_REGS*DATA_W-1:0] modelRegOut();
    logic [NUM_REGS*DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[i*DATA_W +: DATA_W] = m_reg[i];
    return v;
  endfunction

  // One clock edge of the architectural rules, applied to the model state.
  function automatic void modelStep();
    logic s_ok, h_ok, i_ok;
    s_ok = sram_w_valid && !fpu_wb_valid && !m_busy[sram_w_addr];
    h_ok = host_w_valid && !fpu_wb_valid && !sram_w_valid && !m_busy[host_w_addr];
    i_ok = issue_valid && !m_busy[issue_dest];
    if (fpu_wb_valid) begin
      if (!m_busy[fpu_wb_addr]) m_err = 1'b1;
      m_reg[fpu_wb_addr]  = fpu_wb_data;
      m_busy[fpu_wb_addr] = 1'b0;
    end else if (s_ok) begin
      m_reg[sram_w_addr] = sram_w_data;
    end else if (h_ok) begin
      m_reg[host_w_addr] = host_w_data;
    end
    if (i_ok) m_busy[issue_dest] = 1'b1;
    sram_acc = s_ok;
    host_acc = h_ok;
  endfunction

  task automatic applyStimulus(input logic fv, input int fa, input fp_word_t fd,
                               input logic sv, input int sa, input fp_word_t sd,
                               input logic hv, input int ha, input fp_word_t hd,
                               input logic iv, input int id);
    fpu_wb_valid = fv;  fpu_wb_addr = reg_idx_t'(fa);  fpu_wb_data = fd;
    sram_w_valid = sv;  sram_w_addr = reg_idx_t'(sa);  sram_w_data = sd;
    host_w_valid = hv;  host_w_addr = reg_idx_t'(ha);  host_w_data = hd;
    issue_valid  = iv;  issue_dest  = reg_idx_t'(id);
  endtask

  task automatic idle();
    applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, '0, 0, 0);
  endtask

  task automatic checkOutput();
    expectVal("reg_out", reg_out, modelRegOut());
    expectVal("busy", busy, m_busy);
    expectVal("wb_err", wb_err, m_err);
    expectVal("sram_w_ready", sram_w_ready, !fpu_wb_valid && !m_busy[sram_w_addr]);
    expectVal("host_w_ready", host_w_ready,
              !fpu_wb_valid && !sram_w_valid && !m_busy[host_w_addr]);
    expectVal("issue_ready", issue_ready, !m_busy[issue_dest]);
  endtask

  task automatic settle();
    #1;
    checkOutput();
  endtask

  task automatic tick();
    @(posedge clk);
    sram_acc = 1'b0;
    host_acc = 1'b0;
    if (n_rst) modelStep();
    @(negedge clk);
  endtask

  initial begin
    logic sram_pend, host_pend;
    int   list[$];
    int   fa;

    n_rst = 1'b0;
    idle();
    modelReset();
    @(negedge clk);
    settle();
    expectVal("reset_reg_out", reg_out, '0);
    expectVal("reset_busy", busy, '0);
    expectVal("reset_wb_err", wb_err, 1'b0);
    tick();
    n_rst = 1'b1;

    applyStimulus(0, 0, '0, 0, 0, '0, 1, 3, 32'h3F800000, 0, 0);
    settle();
    expectVal("host_ready_alone", host_w_ready, 1'b1);
    tick();
    idle();
    settle();
    expectVal("host_r3", regOf(3), 32'h3F800000);
    tick();

    applyStimulus(1, 1, 32'h40000000, 1, 2, 32'h40400000, 1, 4, 32'h40800000, 0, 0);
    settle();
    expectVal("coll_sram_ready", sram_w_ready, 1'b0);
    expectVal("coll_host_ready", host_w_ready, 1'b0);
    tick();
    applyStimulus(0, 0, '0, 1, 2, 32'h40400000, 1, 4, 32'h40800000, 0, 0);
    settle();
    expectVal("coll_c1_r1", regOf(1), 32'h40000000);
    expectVal("coll_c1_r2", regOf(2), 32'h0);
    expectVal("coll_c1_host_ready", host_w_ready, 1'b0);
    tick();
    applyStimulus(0, 0, '0, 0, 0, '0, 1, 4, 32'h40800000, 0, 0);
    settle();
    expectVal("coll_c2_r2", regOf(2), 32'h40400000);
    expectVal("coll_c2_r4", regOf(4), 32'h0);
    tick();
    idle();
    settle();
    expectVal("coll_c3_r4", regOf(4), 32'h40800000);
    tick();

    applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, '0, 1, 8);
    settle();
    tick();
    idle();
    settle();
    expectVal("pending_busy8", busy, 16'h0100);
    #2;
    n_rst = 1'b0;
    modelReset();
    #1;
    expectVal("midrst_busy", busy, '0);
    expectVal("midrst_reg_out", reg_out, '0);
    expectVal("midrst_wb_err", wb_err, 1'b0);
    checkOutput();
    tick();
    n_rst = 1'b1;

    applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, '0, 1, 5);
    settle();
    expectVal("issue5_ready", issue_ready, 1'b1);
    tick();
    applyStimulus(0, 0, '0, 0, 0, '0, 1, 5, 32'h11111111, 0, 0);
    settle();
    expectVal("sb_busy5", busy[5], 1'b1);
    expectVal("sb_host_blocked", host_w_ready, 1'b0);
    tick();
    settle();
    expectVal("sb_host_held", host_w_ready, 1'b0);
    tick();
    applyStimulus(1, 5, 32'hC0000000, 0, 0, '0, 1, 5, 32'h11111111, 0, 0);
    settle();
    tick();
    applyStimulus(0, 0, '0, 0, 0, '0, 1, 5, 32'h11111111, 0, 0);
    settle();
    expectVal("sb_wb_r5", regOf(5), 32'hC0000000);
    expectVal("sb_busy5_clear", busy[5], 1'b0);
    expectVal("sb_host_ready", host_w_ready, 1'b1);
    tick();
    idle();
    settle();
    expectVal("sb_host_overwrite", regOf(5), 32'h11111111);
    tick();

    applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, '0, 1, 7);
    settle();
    tick();
    settle();
    expectVal("issue7_blocked", issue_ready, 1'b0);
    tick();
    applyStimulus(1, 7, 32'h3F000000, 0, 0, '0, 0, 0, '0, 0, 0);
    settle();
    tick();
    applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, '0, 1, 7);
    settle();
    expectVal("issue7_after_wb", issue_ready, 1'b1);
    tick();
    applyStimulus(1, 7, 32'h0, 0, 0, '0, 0, 0, '0, 1, 6);
    settle();
    tick();
    applyStimulus(1, 6, 32'h41000000, 0, 0, '0, 0, 0, '0, 1, 6);
    settle();
    expectVal("same_cycle_issue_ready", issue_ready, 1'b0);
    tick();
    idle();
    settle();
    expectVal("same_cycle_busy6", busy[6], 1'b0);
    expectVal("clean_wb_err", wb_err, 1'b0);
    tick();

    applyStimulus(1, 9, 32'h12345678, 0, 0, '0, 0, 0, '0, 0, 0);
    settle();
    tick();
    idle();
    settle();
    expectVal("spurious_r9", regOf(9), 32'h12345678);
    expectVal("spurious_wb_err", wb_err, 1'b1);
    tick();
    tick();
    settle();
    expectVal("wb_err_sticky", wb_err, 1'b1);
    tick();

    sram_pend = 1'b0;
    host_pend = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        n_rst = 1'b0;
        modelReset();
        sram_pend = 1'b0;
        host_pend = 1'b0;
      end else begin
        n_rst = 1'b1;
      end
      if (!sram_pend && $urandom_range(0, 2) == 0) begin
        sram_pend    = 1'b1;
        sram_w_addr  = reg_idx_t'($urandom_range(0, NUM_REGS-1));
        sram_w_data  = fp_word_t'($urandom);
      end
      if (!host_pend && $urandom_range(0, 2) == 0) begin
        host_pend    = 1'b1;
        host_w_addr  = reg_idx_t'($urandom_range(0, NUM_REGS-1));
        host_w_data  = fp_word_t'($urandom);
      end
      sram_w_valid = sram_pend;
      host_w_valid = host_pend;
      list.delete();
      for (int i = 0; i < NUM_REGS; i++) if (m_busy[i]) list.push_back(i);
      if (list.size() > 0 && $urandom_range(0, 7) != 0)
        fa = list[$urandom_range(0, list.size()-1)];
      else
        fa = int'($urandom_range(0, NUM_REGS-1));
      fpu_wb_valid = ($urandom_range(0, 2) == 0);
      fpu_wb_addr  = reg_idx_t'(fa);
      fpu_wb_data  = fp_word_t'($urandom);
      issue_valid  = ($urandom_range(0, 2) == 0);
      issue_dest   = reg_idx_t'($urandom_range(0, NUM_REGS-1));
      settle();
      tick();
      if (sram_acc) sram_pend = 1'b0;
      if (host_acc) host_pend = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
